fpall_issue_ctrl: RTL and testbench
===================================

Name: fpall_issue_ctrl

Overview:
Valid/ready flow-control shell placed directly in front of, and behind, fpall_shared. It accepts operation requests on a valid/ready stream and issues them into the fixed-latency fpall_shared datapath. It tracks in-flight operations and their sideband (tag, op, fmt) in a valid shift pipeline. Results land in a result FIFO, and credit-based admission guarantees no result is ever dropped under output backpressure.

Parameters:
LATENCY, 4, cycles from fpall_shared X/Y/opcode/fmt presented to R valid; must equal fpall_shared pipeline depth; legal range >=1
OUT_DEPTH, 4, result FIFO entries and total credit count; legal range >=2
TAG_W, 4, width of user tag carried alongside each operation

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_op  input  2  00 Add, 01 Mul, 10 Sqrt, 11 Div
in_fmt  input  1  0 FP32, 1 FP16
in_x  input  32  operand X
in_y  input  32  operand Y; ignored by Sqrt but still forwarded
in_tag  input  TAG_W  user tag
dut_opcode  output  2  to fpall_shared opcode
dut_fmt  output  1  to fpall_shared fmt
dut_x  output  32  to fpall_shared X
dut_y  output  32  to fpall_shared Y
dut_r  input  32  from fpall_shared R
out_valid  output  1  result valid (FIFO head)
out_ready  input  1  result consumed when out_valid && out_ready
out_r  output  32  result word
out_tag  output  TAG_W  tag of the result
out_op  output  2  op of the result
out_fmt  output  1  fmt of the result
busy  output  1  high when any op is in flight or buffered

Behaviour:
- Issue register: on accept at edge t, latch in_op/in_fmt/in_x/in_y into dut_* registers, and latch in_tag/op/fmt plus valid=1 into pipeline stage 0.
  - dut_* therefore present the operation during cycle t+1.
  - When no accept occurs, dut_* hold their last values and stage-0 valid=0.
- Valid pipeline: LATENCY+1 stages (stage 0 = issue register) shift every cycle unconditionally; the fpall_shared pipeline cannot stall.
  - When the last stage is valid, dut_r is written into the FIFO together with that stage's tag/op/fmt.
  - Result first visible at out_valid in cycle t+LATENCY+2, giving total latency LATENCY+2 from the accept edge.
- Credit counter occ, width clog2(OUT_DEPTH+1):
  - +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
  - occ counts in-flight plus buffered ops.
  - in_ready = !rst && (occ < OUT_DEPTH); registered-path only, no combinational dependence on out_ready or in_valid.
  - Consequence: a FIFO write always finds space; FIFO overflow is impossible. Add an assertion that it never occurs.
- FIFO: OUT_DEPTH entries, first-word-fall-through.
  - out_valid = (count != 0); out_r/tag/op/fmt come from the head entry.
  - Push and pop in the same cycle are allowed at any occupancy, including empty+push (no bypass: the entry appears next cycle) and full+pop.
  - Read and write pointers wrap modulo OUT_DEPTH; OUT_DEPTH need not be a power of two.
- Ordering: results leave in strict issue order.
- busy = (occ != 0).
- Reset (synchronous, any cycle, including mid-operation):
  - Clears occ, FIFO pointers/count and all pipeline valid bits; in-flight and buffered results are discarded.
  - dut_* registers reset to 0.
  - Outputs during and after reset: out_valid=0, busy=0, in_ready=0 while rst=1, in_ready=1 the first cycle after.
  - Stale dut_r values arriving after reset are ignored, because their valid bits were cleared.
- out_* data are don't-care when out_valid=0; the bench checks data only on handshake.

Test Plan:
- Single op, LATENCY=4: accept FP32 Add at edge 0 with X=0x3F800000, Y=0x40000000, tag=3 -> out_valid rises in cycle 6 with out_r=0x40400000, out_tag=3, out_op=00, out_fmt=0; busy falls after the pop.
- Back-to-back, out_ready=1: four ops issued in consecutive cycles
  - Mul 0x40000000*0x40400000 -> 0x40C00000.
  - Sqrt 0x40800000 -> 0x40000000.
  - FP16 Div 0x00004600/0x00004200 -> 0x00004000.
  - FP32 Add as in the first scenario -> 0x40400000.
  - Required: results appear in four consecutive cycles, in order, tags 0..3.
- Backpressure/full: OUT_DEPTH=4, out_ready=0, in_valid held high with 6 requests -> exactly 4 accepted, in_ready=0 from the cycle after the 4th accept, occ=4. Raise out_ready -> one new accept per pop, no lost or duplicated tags.
- Simultaneous push/pop at full: occ=4, FIFO holds 3, 1 in flight, out_ready=1 for one cycle while the in-flight result lands -> count stays 3, occ=3, and in_ready returns to 1 the next cycle.
- Reset mid-operation: rst pulse for one cycle while 2 ops in flight and 1 buffered -> next cycle out_valid=0, busy=0, in_ready=1; no result appears in the following LATENCY+2 cycles.
- Random soak: 10k random ops with random in_valid/out_ready against a reference model -> ordering, tags and values all match, and the FIFO overflow assertion never fires.

Source files
------------

// File: rtl/fpall_issue_ctrl.sv
// fpall_issue_ctrl
//   Valid/ready flow-control shell around the fixed-latency fpall_shared
//   datapath. Requests are registered into the dut_* issue registers,
//   their sideband (tag/op/fmt) travels down a valid shift pipeline that
//   matches the datapath depth, and results are captured into a
//   first-word-fall-through result FIFO. Credit-based admission (occ)
//   reserves a FIFO slot for every accepted op, so results are never
//   dropped under output backpressure.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; in_op/in_fmt/in_x/in_y/in_tag payload
//   dut_opcode/fmt/x/y  registered operation presented to fpall_shared
//   dut_r               fpall_shared result, valid LATENCY cycles after dut_*
//   out_valid/out_ready result handshake; out_r/out_tag/out_op/out_fmt payload
//   busy                any op in flight or buffered
module fpall_issue_ctrl #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_fmt,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic [1:0]       dut_opcode,
    output logic             dut_fmt,
    output logic [31:0]      dut_x,
    output logic [31:0]      dut_y,
    input  logic [31:0]      dut_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_op,
    output logic             out_fmt,
    output logic             busy
);

    localparam int unsigned OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(OUT_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_DEPTH - 1);

    logic [OCC_W-1:0] occ;
    logic             accept;
    logic             push;
    logic             pop;

    // Stage 0 is the issue register; stage LATENCY lines up with dut_r.
    logic [LATENCY:0] pipe_vld;
    logic [TAG_W-1:0] pipe_tag [0:LATENCY];
    logic [1:0]       pipe_op  [0:LATENCY];
    logic             pipe_fmt [0:LATENCY];

    logic [31:0]      fifo_r   [0:OUT_DEPTH-1];
    logic [TAG_W-1:0] fifo_tag [0:OUT_DEPTH-1];
    logic [1:0]       fifo_op  [0:OUT_DEPTH-1];
    logic             fifo_fmt [0:OUT_DEPTH-1];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [OCC_W-1:0] count;

    // in_ready depends only on registered occ (and rst), never on out_ready.
    assign in_ready  = !rst && (occ < OCC_MAX);
    assign accept    = in_valid && in_ready;
    assign push      = pipe_vld[LATENCY];
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = (occ != '0);

    assign out_r   = fifo_r[rptr];
    assign out_tag = fifo_tag[rptr];
    assign out_op  = fifo_op[rptr];
    assign out_fmt = fifo_fmt[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            dut_opcode <= '0;
            dut_fmt    <= '0;
            dut_x      <= '0;
            dut_y      <= '0;
        end else if (accept) begin
            dut_opcode <= in_op;
            dut_fmt    <= in_fmt;
            dut_x      <= in_x;
            dut_y      <= in_y;
        end
    end

    // The datapath cannot stall, so the valid pipeline shifts every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld <= {pipe_vld[LATENCY-1:0], accept};
        end
    end

    // Sideband is only meaningful where pipe_vld is set; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            pipe_tag[0] <= in_tag;
            pipe_op[0]  <= in_op;
            pipe_fmt[0] <= in_fmt;
        end
        for (int unsigned i = 1; i <= LATENCY; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
            pipe_op[i]  <= pipe_op[i-1];
            pipe_fmt[i] <= pipe_fmt[i-1];
        end
    end

    // occ counts in-flight plus buffered ops; it bounds FIFO occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // No bypass: an entry written this edge becomes the head next cycle.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_r[wptr]   <= dut_r;
            fifo_tag[wptr] <= pipe_tag[LATENCY];
            fifo_op[wptr]  <= pipe_op[LATENCY];
            fifo_fmt[wptr] <= pipe_fmt[LATENCY];
        end
    end

    a_no_fifo_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && !pop && (count == OCC_MAX))
    );

endmodule

// File: tb/tb_fpall_issue_ctrl.sv
module tb_fpall_issue_ctrl;

    localparam int unsigned LATENCY   = 4;
    localparam int unsigned OUT_DEPTH = 4;
    localparam int unsigned TAG_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_fmt;
    logic [31:0]      in_x;
    logic [31:0]      in_y;
    logic [TAG_W-1:0] in_tag;
    logic [1:0]       dut_opcode;
    logic             dut_fmt;
    logic [31:0]      dut_x;
    logic [31:0]      dut_y;
    logic [31:0]      dut_r;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_r;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_op;
    logic             out_fmt;
    logic             busy;

    fpall_issue_ctrl #(.LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_fmt(in_fmt),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .dut_opcode(dut_opcode), .dut_fmt(dut_fmt), .dut_x(dut_x), .dut_y(dut_y),
        .dut_r(dut_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
        .out_op(out_op), .out_fmt(out_fmt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for fpall_shared: known vectors give true results, anything
    // else gets an arbitrary but deterministic mix of the operands.
    function automatic logic [31:0] fp_model(input logic [1:0] op, input logic fmt,
                                             input logic [31:0] x, input logic [31:0] y);
        if (op == 2'b00 && !fmt && x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
        if (op == 2'b01 && !fmt && x == 32'h40000000 && y == 32'h40400000) return 32'h40C00000;
        if (op == 2'b10 && !fmt && x == 32'h40800000) return 32'h40000000;
        if (op == 2'b11 && fmt && x == 32'h00004600 && y == 32'h00004200) return 32'h00004000;
        return x ^ {y[15:0], y[31:16]} ^ {29'h0, fmt, op};
    endfunction

    logic [31:0] mpipe [0:LATENCY-1];
    always @(posedge clk) begin
        mpipe[0] <= fp_model(dut_opcode, dut_fmt, dut_x, dut_y);
        for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
    assign dut_r = mpipe[LATENCY-1];

    typedef struct {
        logic [1:0]       op;
        logic             fmt;
        logic [31:0]      x;
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_r;
    } vec_t;

    vec_t vecs [4];

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int n_acc    = 0;
    bit last_acc;
    bit last_pop;
    logic [31:0] cur_exp;
    logic [38:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: score handshakes seen before the edge, then advance.
    task automatic tick();
        last_acc = in_valid && in_ready;
        last_pop = out_valid && out_ready;
        if (last_pop) begin
            n_pops++;
            if (sb.size() == 0) begin
                check("unexpected_pop", 64'(out_tag), 64'hFFFF);
            end else begin
                check("result", 64'({out_r, out_tag, out_op, out_fmt}), 64'(sb[0]));
                void'(sb.pop_front());
            end
        end
        if (last_acc) begin
            n_acc++;
            sb.push_back({cur_exp, in_tag, in_op, in_fmt});
        end
        if (rst) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic fmt, input logic [31:0] x,
                         input logic [31:0] y, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_fmt   = fmt;
        in_x     = x;
        in_y     = y;
        in_tag   = tag;
        cur_exp  = fp_model(op, fmt, x, y);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max, output int n);
        n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
        if (!out_valid) check({name, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        int n;
        int next_tag;
        int pops0;
        int cyc;

        vecs[0] = '{op: 2'b01, fmt: 1'b0, x: 32'h40000000, y: 32'h40400000, tag: 4'd0, exp_r: 32'h40C00000};
        vecs[1] = '{op: 2'b10, fmt: 1'b0, x: 32'h40800000, y: 32'h00000000, tag: 4'd1, exp_r: 32'h40000000};
        vecs[2] = '{op: 2'b11, fmt: 1'b1, x: 32'h00004600, y: 32'h00004200, tag: 4'd2, exp_r: 32'h00004000};
        vecs[3] = '{op: 2'b00, fmt: 1'b0, x: 32'h3F800000, y: 32'h40000000, tag: 4'd3, exp_r: 32'h40400000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_fmt = 1'b0; in_x = '0; in_y = '0; in_tag = '0; cur_exp = '0;
        #1;
        tick(); tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dut_x", 64'(dut_x), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single op: visible LATENCY+1 observations after the accept edge.
        drive(2'b00, 1'b0, 32'h3F800000, 32'h40000000, 4'd3);
        tick();
        check("single_acc", 64'(last_acc), 64'd1);
        idle_in();
        check("single_dut_x", 64'(dut_x), 64'h3F800000);
        wait_valid("single", 20, n);
        check("single_latency", 64'(n), 64'(LATENCY + 1));
        check("single_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_busy_after", 64'(busy), 64'd0);
        check("single_valid_after", 64'(out_valid), 64'd0);

        // Back-to-back table vectors with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i].op, vecs[i].fmt, vecs[i].x, vecs[i].y, vecs[i].tag);
            cur_exp = vecs[i].exp_r;
            tick();
            check("b2b_acc", 64'(last_acc), 64'd1);
        end
        idle_in();
        wait_valid("b2b", 20, n);
        check("b2b_first", 64'(n), 64'd2);
        for (int i = 0; i < 4; i++) begin
            check("b2b_consec", 64'(out_valid), 64'd1);
            tick();
        end
        check("b2b_drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Backpressure: six requests, only OUT_DEPTH accepted while blocked.
        next_tag = 0;
        for (int k = 0; k < 6; k++) begin
            drive(2'b00, 1'b0, 32'h1000 + 32'(next_tag), 32'h77, 4'(next_tag));
            tick();
            if (last_acc) begin
                next_tag++;
                if (next_tag == 4) check("bp_ready_drop", 64'(in_ready), 64'd0);
            end
        end
        check("bp_accepts", 64'(next_tag), 64'd4);
        check("bp_busy", 64'(busy), 64'd1);
        pops0 = n_pops;
        out_ready = 1'b1;
        cyc = 0;
        while ((next_tag < 6 || sb.size() != 0) && cyc < 100) begin
            if (next_tag < 6) drive(2'b00, 1'b0, 32'h1000 + 32'(next_tag), 32'h77, 4'(next_tag));
            else idle_in();
            tick();
            if (last_acc) next_tag++;
            cyc++;
        end
        idle_in();
        check("bp_all_out", 64'(n_pops - pops0), 64'd6);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);
        out_ready = 1'b0;

        // Full occupancy: 3 buffered, 1 in flight, pop as the last one lands.
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 1'b0, 32'h200 + 32'(i), 32'h5, 4'(8 + i));
            tick();
        end
        idle_in();
        for (int i = 0; i < 4; i++) tick();
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_ready_back", 64'(in_ready), 64'd1);
        check("full_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 10) begin
            tick();
            n++;
        end
        check("full_remaining", 64'(n), 64'd3);
        out_ready = 1'b0;

        // Reset with 1 buffered and 2 in flight.
        drive(2'b10, 1'b0, 32'h300, 32'h0, 4'd1);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) tick();
        drive(2'b10, 1'b0, 32'h301, 32'h0, 4'd2);
        tick();
        drive(2'b10, 1'b0, 32'h302, 32'h0, 4'd3);
        tick();
        idle_in();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < int'(LATENCY) + 2; i++) begin
            tick();
            check("mid_rst_no_result", 64'(out_valid), 64'd0);
        end

        // Random soak against the scoreboard.
        next_tag = 0;
        pops0 = n_pops;
        n = n_acc;
        cyc = 0;
        while ((n_acc - n) < 10000 && cyc < 60000) begin
            if ($urandom_range(3) != 0)
                drive(2'($urandom_range(3)), 1'($urandom_range(1)), $urandom, $urandom, 4'(next_tag));
            else
                idle_in();
            out_ready = ($urandom_range(3) != 0);
            tick();
            if (last_acc) next_tag++;
            cyc++;
        end
        idle_in();
        out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("soak_accepts", 64'(n_acc - n), 64'd10000);
        check("soak_pops", 64'(n_pops - pops0), 64'd10000);
        check("soak_sb_empty", 64'(sb.size()), 64'd0);
        check("soak_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
